// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum (IDLE/REQ/VALID) and default widths
// PC_W_DEF / INST_W_DEF used as parameter defaults by fetch_ctrl.
package fetch_pkg;

  localparam int PC_W_DEF   = 8;
  localparam int INST_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counters for fetches accepted and branch redirects taken.
// Latency: count visible one cycle after the increment strobe.
// Backpressure: none; strobes are single-cycle events, counters stick at 16'hFFFF.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_inc, redirect_inc       one-cycle increment strobes
//   fetch_count, redirect_count   16-bit saturating counts, reset to 0
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        redirect_inc,
  output logic [15:0] fetch_count,
  output logic [15:0] redirect_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count    <= 16'h0000;
      redirect_count <= 16'h0000;
    end else begin
      if (fetch_inc && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if (redirect_inc && (redirect_count != 16'hFFFF))
        redirect_count <= redirect_count + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE -> REQ (wait imem_ready) -> VALID (hold until accepted).
// Latency: instruction valid 1 cycle after imem_ready; peak one instruction per 2 cycles.
// Backpressure: stall in VALID freezes all state and outputs; branch is only sampled on release.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall, branch, branch_offset  downstream hold, PC-relative redirect request and offset
//   imem_req, imem_addr           fetch request (registered) and address (= PC)
//   imem_ready, imem_rdata        memory read data valid strobe and data
//   inst_valid, inst_out, inst_pc held instruction (inst_valid registered) and its address
//   fetch_count, redirect_count   saturating perf counters, only when FETCH_PERF_CNT_EN is defined
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int INST_W   = INST_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic [PC_W-1:0]   branch_offset,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       redirect_count
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            fetch_acc;
  logic            redirect_tkn;

  assign imem_addr = pc;

  // Event strobes shared by the FSM and the optional counters.
  assign fetch_acc    = (state == REQ) && imem_ready;
  assign redirect_tkn = (state == VALID) && !stall && branch;

  // imem_req and inst_valid are kept as their own flops, updated alongside
  // the state so they always equal the decode of the state just entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= PC_W'(RESET_PC);
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            inst_out   <= imem_rdata;
            inst_pc    <= pc;
            pc         <= pc + PC_W'(1);
            state      <= VALID;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        VALID: begin
          if (!stall) begin
            // pc already points past inst_pc; a redirect is relative to the
            // held instruction, not to the sequential successor. Wraps mod 2^PC_W.
            if (branch)
              pc <= inst_pc + branch_offset;
            state      <= REQ;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc      (fetch_acc),
    .redirect_inc   (redirect_tkn),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );
`else
  // Strobes have no consumer without the counters.
  logic unused_strobes;
  assign unused_strobes = fetch_acc ^ redirect_tkn;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the width of the program counter, branch offset and instruction address.
REQ-002 Parameter INST_W, default 32, SHALL set the width of the instruction word.
REQ-003 Parameter RESET_PC, default 0, SHALL set the value loaded into the PC on reset.
REQ-004 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  SHALL be the reset: one clock, reset is synchronous and active-high.
REQ-006 Port stall  in  1  SHALL mean the downstream stage cannot accept the presented instruction.
REQ-007 Port branch  in  1  SHALL request a PC-relative redirect for the presented instruction.
REQ-008 Port branch_offset  in  PC_W  SHALL be the redirect offset, two's-complement.
REQ-009 Port imem_ready  in  1  SHALL mean imem_rdata is valid for the current imem_addr this cycle.
REQ-010 Port imem_rdata  in  INST_W  SHALL be the instruction memory read data.
REQ-011 Port imem_req  out  1  SHALL request a fetch at imem_addr.
REQ-012 Port imem_addr  out  PC_W  SHALL be the fetch address, equal to the current PC.
REQ-013 Port inst_valid  out  1  SHALL mean inst_out and inst_pc are valid.
REQ-014 Port inst_out  out  INST_W  SHALL be the held instruction.
REQ-015 Port inst_pc  out  PC_W  SHALL be the address the held instruction was fetched from.

Function
REQ-016 FSM states SHALL be IDLE, REQ and VALID; IDLE always advances to REQ on the next cycle.
REQ-017 In REQ, imem_req SHALL be 1; on imem_ready=1, inst_out<=imem_rdata, inst_pc<=PC, PC<=PC+1, and the FSM moves to VALID; otherwise it stays in REQ with PC unchanged.
REQ-018 In VALID, inst_valid SHALL be 1 and imem_req 0.
REQ-019 In VALID with stall=1, all state and outputs SHALL hold; branch is ignored (the requester holds it).
REQ-020 In VALID with stall=0 and branch=0, the FSM SHALL move to REQ with PC unchanged (already PC+1).
REQ-021 In VALID with stall=0 and branch=1, PC<=inst_pc+branch_offset and the FSM SHALL move to REQ.
REQ-022 PC arithmetic SHALL be modulo 2^PC_W (wrap, no saturation or flag); 8'hFF+1=8'h00.
REQ-023 branch outside VALID SHALL have no effect.
REQ-024 Peak throughput SHALL be one instruction per 2 cycles; fetch latency is 1 cycle after imem_ready.
REQ-025 inst_valid, imem_req SHALL be registered outputs; imem_addr SHALL equal PC.

Reset
REQ-026 rst=1 SHALL, on the next rising edge, force state=IDLE, PC=RESET_PC, inst_valid=0, imem_req=0, inst_out=0, inst_pc=0, regardless of state or in-flight handshake; rst overrides branch and stall.

Configuration
REQ-027 With FETCH_PERF_CNT_EN defined, outputs fetch_count[15:0] (incremented per accepted imem_ready) and redirect_count[15:0] (incremented per taken branch, REQ-021) SHALL exist, saturate at 16'hFFFF, and reset to 0.
REQ-028 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum (IDLE/REQ/VALID) and default width constants PC_W_DEF=8, INST_W_DEF=32.
REQ-030 Counters SHALL be a sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-031 Reset, imem_ready tied 1, stall=0, branch=0 -> imem_addr 0,1,2... on alternate cycles; inst_pc 0,1,2 with inst_valid every other cycle.
REQ-032 inst_pc=8'h10 in VALID, branch=1, branch_offset=8'hFC, stall=0 -> next imem_addr=8'h0C; redirect_count+1 if enabled.
REQ-033 VALID with stall=1 for 5 cycles and branch=1 throughout -> inst_out/inst_pc/PC stable; on stall release, redirect taken once.
REQ-034 PC=8'hFF, imem_ready=1 -> inst_pc=8'hFF, next imem_addr=8'h00.
REQ-035 imem_ready=0 for 3 cycles in REQ -> imem_req held 1, imem_addr unchanged, inst_valid 0; rst=1 mid-wait -> IDLE, PC=RESET_PC next edge.
REQ-036 FETCH_PERF_CNT_EN build, fetch_count preloaded near 16'hFFFF -> saturates at 16'hFFFF, no wrap.
